// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle reduced RISC-V core: sequences fetch/decode/execute/memory/writeback.
// Optional feature macro ILLEGAL_OP_TRAP_EN: unsupported opcodes lock the FSM in TRAP and raise illegal_o.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [6:0]       op_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7b5_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_write_o,
    output logic [1:0]       result_src_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_ctrl_o,
    output logic [1:0]       imm_src_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             illegal_o
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
`ifdef ILLEGAL_OP_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_instret;
    logic [2:0]       w_alu_dec;

    // funct7b5 only selects sub for register-register ops; addi never subtracts
    always_comb begin
        w_alu_dec = ALU_ADD;
        case (funct3_i)
            3'b000:  w_alu_dec = (op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_dec = ALU_SLT;
            3'b110:  w_alu_dec = ALU_OR;
            3'b111:  w_alu_dec = ALU_AND;
            default: w_alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:    if (mem_ready_i) w_next = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      w_next = S_TRAP;
`else
                    default:      w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready_i) w_next = S_MEMWB;
            S_MEMWB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEMWRITE: if (mem_ready_i) begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_EXECR, S_EXECI: w_next = S_ALUWB;
            S_ALUWB, S_BEQ: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_JAL:      w_next = S_ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:     w_next = S_TRAP;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + 1'b1;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk_i) begin
        if (!rst_ni)                 r_illegal <= 1'b0;
        else if (w_next == S_TRAP)   r_illegal <= 1'b1;
    end
    assign illegal_o = r_illegal;
`else
    assign illegal_o = 1'b0;
`endif

    assign instret_o = r_instret;

    // Reset gates every control line combinationally so an in-flight access is dropped at once
    always_comb begin
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        result_src_o = 2'b00;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_ctrl_o   = ALU_ADD;
        imm_src_o    = 2'b00;
        if (rst_ni) begin
            case (op_i)
                OP_SW:   imm_src_o = 2'd1;
                OP_BEQ:  imm_src_o = 2'd2;
                OP_JAL:  imm_src_o = 2'd3;
                default: imm_src_o = 2'd0;
            endcase
            case (r_state)
                S_FETCH: begin
                    mem_req_o    = 1'b1;
                    alu_src_b_o  = 2'b10;
                    result_src_o = 2'b10;
                    ir_write_o   = mem_ready_i;
                    pc_write_o   = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a_o = 2'b10;
                    alu_src_b_o = 2'b01;
                end
                S_MEMREAD: begin
                    mem_req_o = 1'b1;
                    adr_src_o = 1'b1;
                end
                S_MEMWB: begin
                    result_src_o = 2'b01;
                    reg_write_o  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req_o   = 1'b1;
                    mem_write_o = 1'b1;
                    adr_src_o   = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a_o = 2'b10;
                    alu_ctrl_o  = w_alu_dec;
                end
                S_EXECI: begin
                    alu_src_a_o = 2'b10;
                    alu_src_b_o = 2'b01;
                    alu_ctrl_o  = w_alu_dec;
                end
                S_ALUWB: reg_write_o = 1'b1;
                S_BEQ: begin
                    alu_src_a_o = 2'b10;
                    alu_ctrl_o  = ALU_SUB;
                    pc_write_o  = zero_i;
                end
                S_JAL: begin
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b10;
                    pc_write_o  = 1'b1;
                end
                default: ;
            endcase
`ifdef ILLEGAL_OP_TRAP_EN
            if (r_state == S_TRAP) imm_src_o = 2'b00;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, memory stalls, reset mid-access and illegal opcodes.
module tb_multicycle_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [6:0]  op_i;
    logic [2:0]  funct3_i;
    logic        funct7b5_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0]  result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o;
    logic [2:0]  alu_ctrl_o;
    logic [31:0] instret_o;
    logic        illegal_o;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .op_i(op_i), .funct3_i(funct3_i),
        .funct7b5_i(funct7b5_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .adr_src_o(adr_src_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
        .result_src_o(result_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_ctrl_o(alu_ctrl_o), .imm_src_o(imm_src_o), .instret_o(instret_o),
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock, then settle away from the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; op_i = 7'b0110011; funct3_i = 3'b000; funct7b5_i = 1'b1;
        zero_i = 1'b0; mem_ready_i = 1'b1;
        tick(); tick();
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_ir_write", {31'd0, ir_write_o}, 32'd0);
        chk("rst_instret", instret_o, 32'd0);
        chk("rst_illegal", {31'd0, illegal_o}, 32'd0);

        // FETCH stall then R-type sub
        rst_ni = 1'b1; mem_ready_i = 1'b0; #1;
        chk("fetch_req", {31'd0, mem_req_o}, 32'd1);
        chk("fetch_stall_irw", {31'd0, ir_write_o}, 32'd0);
        chk("fetch_stall_pcw", {31'd0, pc_write_o}, 32'd0);
        tick();
        chk("fetch_still", {31'd0, mem_req_o}, 32'd1);
        mem_ready_i = 1'b1; #1;
        chk("fetch_irw", {31'd0, ir_write_o}, 32'd1);
        chk("fetch_pcw", {31'd0, pc_write_o}, 32'd1);
        chk("fetch_srcb", {30'd0, alu_src_b_o}, 32'd2);
        chk("fetch_res", {30'd0, result_src_o}, 32'd2);
        tick();
        chk("dec_srca", {30'd0, alu_src_a_o}, 32'd1);
        chk("dec_srcb", {30'd0, alu_src_b_o}, 32'd1);
        chk("dec_req", {31'd0, mem_req_o}, 32'd0);
        tick();
        chk("execr_sub", {29'd0, alu_ctrl_o}, 32'd1);
        chk("execr_srca", {30'd0, alu_src_a_o}, 32'd2);
        chk("execr_srcb", {30'd0, alu_src_b_o}, 32'd0);
        tick();
        chk("aluwb_rw", {31'd0, reg_write_o}, 32'd1);
        chk("aluwb_cnt_pre", instret_o, 32'd0);
        tick();
        chk("r_retired", instret_o, 32'd1);
        chk("r_back_fetch", {31'd0, mem_req_o}, 32'd1);

        // lw with three wait cycles in MEMREAD
        op_i = 7'b0000011; funct3_i = 3'b010; #1;
        chk("lw_imm", {30'd0, imm_src_o}, 32'd0);
        tick(); tick();
        chk("memadr_srca", {30'd0, alu_src_a_o}, 32'd2);
        chk("memadr_srcb", {30'd0, alu_src_b_o}, 32'd1);
        tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready_i = 1'b1;
            #1;
            chk("memrd_req", {31'd0, mem_req_o}, 32'd1);
            chk("memrd_adr", {31'd0, adr_src_o}, 32'd1);
            chk("memrd_wr", {31'd0, mem_write_o}, 32'd0);
            tick();
        end
        chk("memwb_res", {30'd0, result_src_o}, 32'd1);
        chk("memwb_rw", {31'd0, reg_write_o}, 32'd1);
        tick();
        chk("lw_retired", instret_o, 32'd2);

        // beq taken, then not taken
        op_i = 7'b1100011; zero_i = 1'b1; #1;
        chk("beq_imm", {30'd0, imm_src_o}, 32'd2);
        tick(); tick();
        chk("beq_pcw_taken", {31'd0, pc_write_o}, 32'd1);
        chk("beq_sub", {29'd0, alu_ctrl_o}, 32'd1);
        tick();
        chk("beq1_cnt", instret_o, 32'd3);
        zero_i = 1'b0;
        tick(); tick();
        chk("beq_pcw_not", {31'd0, pc_write_o}, 32'd0);
        tick();
        chk("beq2_cnt", instret_o, 32'd4);

        // jal
        op_i = 7'b1101111; #1;
        chk("jal_imm", {30'd0, imm_src_o}, 32'd3);
        tick(); tick();
        chk("jal_pcw", {31'd0, pc_write_o}, 32'd1);
        chk("jal_srca", {30'd0, alu_src_a_o}, 32'd1);
        chk("jal_srcb", {30'd0, alu_src_b_o}, 32'd2);
        tick();
        chk("jal_wb_rw", {31'd0, reg_write_o}, 32'd1);
        chk("jal_wb_cnt", instret_o, 32'd4);
        tick();
        chk("jal_retired", instret_o, 32'd5);

        // sw, zero wait states: 4 cycles
        op_i = 7'b0100011; #1;
        chk("sw_imm", {30'd0, imm_src_o}, 32'd1);
        tick(); tick(); tick();
        chk("memwr_wr", {31'd0, mem_write_o}, 32'd1);
        chk("memwr_adr", {31'd0, adr_src_o}, 32'd1);
        tick();
        chk("sw_retired", instret_o, 32'd6);

        // sw stalled, reset during the wait
        tick(); tick(); tick();
        mem_ready_i = 1'b0; #1;
        chk("sw_wait_wr", {31'd0, mem_write_o}, 32'd1);
        tick();
        chk("sw_wait_req", {31'd0, mem_req_o}, 32'd1);
        rst_ni = 1'b0; #1;
        chk("sw_rst_wr", {31'd0, mem_write_o}, 32'd0);
        chk("sw_rst_req", {31'd0, mem_req_o}, 32'd0);
        tick();
        rst_ni = 1'b1; #1;
        chk("post_rst_cnt", instret_o, 32'd0);
        chk("post_rst_wr", {31'd0, mem_write_o}, 32'd0);
        chk("post_rst_adr", {31'd0, adr_src_o}, 32'd0);
        chk("post_rst_fetch", {31'd0, mem_req_o}, 32'd1);
        mem_ready_i = 1'b1;

        // I-type addi with funct7b5 set must still add
        op_i = 7'b0010011; funct3_i = 3'b000; funct7b5_i = 1'b1;
        tick(); tick();
        chk("execi_add", {29'd0, alu_ctrl_o}, 32'd0);
        chk("execi_srcb", {30'd0, alu_src_b_o}, 32'd1);
        tick(); tick();
        chk("i_retired", instret_o, 32'd1);

        // R-type and / or / slt
        op_i = 7'b0110011; funct3_i = 3'b111;
        tick(); tick();
        chk("execr_and", {29'd0, alu_ctrl_o}, 32'd2);
        funct3_i = 3'b110; #1;
        chk("execr_or", {29'd0, alu_ctrl_o}, 32'd3);
        funct3_i = 3'b010; #1;
        chk("execr_slt", {29'd0, alu_ctrl_o}, 32'd5);
        tick(); tick();
        chk("and_retired", instret_o, 32'd2);

        // unsupported opcode
        op_i = 7'b1111111; #1;
        chk("ill_imm", {30'd0, imm_src_o}, 32'd0);
        tick(); tick();
`ifdef ILLEGAL_OP_TRAP_EN
        chk("trap_illegal", {31'd0, illegal_o}, 32'd1);
        chk("trap_req", {31'd0, mem_req_o}, 32'd0);
        tick();
        chk("trap_hold_req", {31'd0, mem_req_o}, 32'd0);
        chk("trap_hold_ill", {31'd0, illegal_o}, 32'd1);
`else
        chk("nop_fetch", {31'd0, mem_req_o}, 32'd1);
        chk("nop_illegal", {31'd0, illegal_o}, 32'd0);
`endif
        chk("ill_cnt", instret_o, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle reduced RISC-V core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, memory port and register file.
- Drives ImmSrc to the immediate sign extender and all datapath mux selects.
- Handshakes with the unified instruction/data memory and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  synchronous active-low reset.
- op_i  in  7  instruction opcode field (instr[6:0]).
- funct3_i  in  3  instr[14:12].
- funct7b5_i  in  1  instr[30].
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes the current access this cycle.
- mem_req_o  out  1  memory access request.
- mem_write_o  out  1  store strobe; valid while mem_req_o=1.
- adr_src_o  out  1  memory address select: 0=PC, 1=Result.
- ir_write_o  out  1  load instruction register and OldPC.
- pc_write_o  out  1  PC update enable.
- reg_write_o  out  1  register-file write enable.
- result_src_o  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- alu_src_a_o  out  2  ALU A select: 00=PC, 01=OldPC, 10=RegA.
- alu_src_b_o  out  2  ALU B select: 00=RegB, 01=ImmExt, 10=const 4.
- alu_ctrl_o  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- imm_src_o  out  2  immediate format to the sign extender: 0=I, 1=S, 2=B, 3=J.
- instret_o  out  CNT_W  retired-instruction count.
- illegal_o  out  1  sticky illegal-opcode flag; used only with the optional feature.

Behaviour:
- Supported opcodes:
  - lw 0000011, sw 0100011, R-ALU 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
  - Any other opcode is unsupported.
- imm_src_o is combinational from op_i in every state:
  - lw/I-ALU=0, sw=1, beq=2, jal=3, unsupported=0.
- All outputs are a function of state; the only input-dependent outputs are the gating by mem_ready_i/zero_i below and the funct-based ALU decode. Unlisted outputs are 0 in each state.
- States and transitions:
  - FETCH:
    - mem_req=1, adr_src=0, alu_a=00, alu_b=10, add, result_src=10.
    - ir_write=pc_write=mem_ready_i.
    - Stay in FETCH until mem_ready_i=1, then go to DECODE.
  - DECODE:
    - alu_a=01, alu_b=01, add (precomputes branch target).
    - Next state: lw/sw->MEMADR, R->EXECR, I->EXECI, beq->BEQ, jal->JAL, unsupported->FETCH.
  - MEMADR: alu_a=10, alu_b=01, add. Next: lw->MEMREAD, sw->MEMWRITE.
  - MEMREAD: mem_req=1, adr_src=1, result_src=00. Wait for mem_ready_i, then MEMWB.
  - MEMWB: result_src=01, reg_write=1, retire; then FETCH.
  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Wait for mem_ready_i, then retire and go to FETCH.
  - EXECR: alu_a=10, alu_b=00, ALU decode. Next ALUWB.
  - EXECI: alu_a=10, alu_b=01, ALU decode. Next ALUWB.
  - ALUWB: result_src=00, reg_write=1, retire; then FETCH.
  - BEQ: alu_a=10, alu_b=00, sub, result_src=00, pc_write=zero_i; retire; then FETCH.
  - JAL: alu_a=01, alu_b=10, add, result_src=00, pc_write=1. Next ALUWB (writes rd=PC+4; retire counted in ALUWB only).
- ALU decode for EXECR/EXECI, keyed on funct3:
  - 000: sub only if R-type and funct7b5=1, else add.
  - 010: slt. 110: or. 111: and. Other funct3: add.
- instret_o increments by exactly 1 on each retire cycle; it wraps from all-ones to 0.
- Memory handshake:
  - mem_req_o is held high and adr_src/mem_write are held stable until mem_ready_i=1.
  - mem_ready_i is ignored when mem_req_o=0.
- Reset:
  - rst_ni=0 at a clock edge sets state=FETCH, instret_o=0, illegal_o=0.
  - All control outputs are forced to 0 while rst_ni=0, including mid-access; the in-flight access is abandoned.
- Cycle counts with zero memory wait states: lw 5, sw 4, R/I 4, beq 3, jal 4.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - An unsupported opcode in DECODE goes to state TRAP.
  - TRAP drives all control outputs to 0, sets illegal_o=1 and stays in TRAP until reset; nothing is retired.
- Undefined:
  - An unsupported opcode goes DECODE->FETCH, not retired (acts as a 2-cycle NOP).
  - illegal_o is tied to 0 and no TRAP state exists.

Test Plan:
- Reset then mem_ready_i=1 always, op_i=0110011, funct3=000, funct7b5=1 -> states FETCH,DECODE,EXECR,ALUWB; alu_ctrl_o=001 in EXECR; reg_write_o=1 in cycle 4; instret_o=1 after.
- lw with mem_ready_i low for 3 cycles in MEMREAD -> mem_req_o=1 and adr_src_o=1 for 4 cycles; MEMWB follows with result_src_o=01; imm_src_o=0; total 8 cycles.
- beq with zero_i=1 then zero_i=0 -> pc_write_o=1 in BEQ for the first and 0 for the second; imm_src_o=2; instret_o=2.
- jal -> imm_src_o=3; pc_write_o=1 in JAL; reg_write_o=1 in the next cycle; instret_o increments once.
- rst_ni=0 asserted during MEMWRITE wait -> next cycle state=FETCH, instret_o=0, mem_write_o=0.
- op_i=1111111 -> with ILLEGAL_OP_TRAP_EN, illegal_o=1 from the cycle after DECODE and mem_req_o held 0; without it, back to FETCH in 2 cycles with instret_o unchanged.
